// File: rtl/flpt_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : flpt_sched_if
//  Description : Handshake bundle between the main decoder, the FP execute
//                sequencer and the FP unit start/select lines.
//  Revision    : 1.0  initial release
// ============================================================================
interface flpt_sched_if;
    logic       req;
    logic [6:0] funct7;
    logic [4:0] rs2f;
    logic [4:0] unit_start;
    logic [2:0] unit_sel;
    logic       busy;
    logic       flpt_done;
    logic       fregwrite;
    logic       iregwrite;
    logic       illegal;

    modport master (
        output req, funct7, rs2f,
        input  unit_start, unit_sel, busy, flpt_done, fregwrite, iregwrite, illegal
    );

    modport slave (
        input  req, funct7, rs2f,
        output unit_start, unit_sel, busy, flpt_done, fregwrite, iregwrite, illegal
    );
endinterface
`default_nettype wire

// File: rtl/flpt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : flpt_sched
//  Description : FP execute sequencer: decodes FTYPE fields, starts the fixed
//                latency FP unit, counts its latency and signals completion.
//  Revision    : 1.0  initial release
// ============================================================================
module flpt_sched #(
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 8,
    parameter int SQRT_LAT = 8,
    parameter int MISC_LAT = 1,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    flpt_sched_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [2:0] c_CL_ADD  = 3'd0;
    localparam logic [2:0] c_CL_MUL  = 3'd1;
    localparam logic [2:0] c_CL_DIV  = 3'd2;
    localparam logic [2:0] c_CL_SQRT = 3'd3;
    localparam logic [2:0] c_CL_MISC = 3'd4;

    localparam logic [CNT_W-1:0] c_ADD_LD  = CNT_W'(ADD_LAT  - 1);
    localparam logic [CNT_W-1:0] c_MUL_LD  = CNT_W'(MUL_LAT  - 1);
    localparam logic [CNT_W-1:0] c_DIV_LD  = CNT_W'(DIV_LAT  - 1);
    localparam logic [CNT_W-1:0] c_SQRT_LD = CNT_W'(SQRT_LAT - 1);
    localparam logic [CNT_W-1:0] c_MISC_LD = CNT_W'(MISC_LAT - 1);
    localparam logic [CNT_W-1:0] c_ZERO    = '0;
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_class;
    logic             r_fwr;
    logic             r_iwr;
    logic             r_illegal;

    logic [2:0]       w_class;
    logic             w_fwr;
    logic             w_iwr;
    logic             w_legal;
    logic [CNT_W-1:0] w_ld;

    always_comb begin
        w_class = c_CL_ADD;
        w_fwr   = 1'b0;
        w_iwr   = 1'b0;
        w_legal = 1'b1;
        case (bus.funct7)
            7'b0000000, 7'b0000100: w_fwr = 1'b1;
            7'b0001000: begin w_class = c_CL_MUL; w_fwr = 1'b1; end
            7'b0001100: begin w_class = c_CL_DIV; w_fwr = 1'b1; end
            7'b0101100: begin
                // rs2 is a reserved field for sqrt and must be zero
                if (bus.rs2f == 5'd0) begin
                    w_class = c_CL_SQRT;
                    w_fwr   = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            7'b0010000, 7'b1111000, 7'b1101000: begin w_class = c_CL_MISC; w_fwr = 1'b1; end
            7'b1010000, 7'b1110000, 7'b1100000: begin w_class = c_CL_MISC; w_iwr = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (r_class)
            c_CL_ADD:  w_ld = c_ADD_LD;
            c_CL_MUL:  w_ld = c_MUL_LD;
            c_CL_DIV:  w_ld = c_DIV_LD;
            c_CL_SQRT: w_ld = c_SQRT_LD;
            default:   w_ld = c_MISC_LD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= c_IDLE;
            r_cnt     <= c_ZERO;
            r_class   <= c_CL_ADD;
            r_fwr     <= 1'b0;
            r_iwr     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req) begin
                        if (w_legal) begin
                            r_class   <= w_class;
                            r_fwr     <= w_fwr;
                            r_iwr     <= w_iwr;
                            r_illegal <= 1'b0;
                            r_state   <= c_ISSUE;
                        end else begin
                            r_class   <= c_CL_ADD;
                            r_fwr     <= 1'b0;
                            r_iwr     <= 1'b0;
                            r_illegal <= 1'b1;
                            r_state   <= c_DONE;
                        end
                    end
                end
                c_ISSUE: begin
                    // a load value of zero means a single-cycle unit
                    r_cnt   <= w_ld;
                    r_state <= (w_ld == c_ZERO) ? c_DONE : c_WAIT;
                end
                c_WAIT: begin
                    r_cnt <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_illegal <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (r_state != c_IDLE);
    assign bus.unit_start = (r_state == c_ISSUE) ? (5'b00001 << r_class) : 5'd0;
    assign bus.unit_sel   = bus.busy ? r_class : 3'd0;
    assign bus.flpt_done  = (r_state == c_DONE);
    assign bus.fregwrite  = (r_state == c_DONE) && r_fwr;
    assign bus.iregwrite  = (r_state == c_DONE) && r_iwr;
    assign bus.illegal    = (r_state == c_DONE) && r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_flpt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flpt_sched
//  Description : Directed self-checking bench for the FP execute sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flpt_sched;

    logic        clk;
    logic        rstn;
    logic [12:0] obs;
    int          n_checks;
    int          n_fail;

    flpt_sched_if bus();

    flpt_sched #(
        .ADD_LAT (2),
        .MUL_LAT (2),
        .DIV_LAT (8),
        .SQRT_LAT(8),
        .MISC_LAT(1),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    // {unit_start, unit_sel, busy, flpt_done, fregwrite, iregwrite, illegal}
    assign obs = {bus.unit_start, bus.unit_sel, bus.busy, bus.flpt_done,
                  bus.fregwrite, bus.iregwrite, bus.illegal};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit=200000 required=finish");
        $fatal(1);
    end

    task automatic test_reset();
        rstn = 1'b0; bus.req = 1'b1; bus.funct7 = 7'b0000000; bus.rs2f = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== 13'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: obs=%b expected=%b", i, obs, 13'd0);
            end
        end
        rstn = 1'b1; bus.req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_idle: obs=%b expected=%b", obs, 13'd0);
        end
    endtask

    task automatic test_fadd();
        logic [12:0] ev [4];
        ev[0] = {5'b00001, 3'd0, 5'b10000};
        ev[1] = {5'b00000, 3'd0, 5'b10000};
        ev[2] = {5'b00000, 3'd0, 5'b11100};
        ev[3] = 13'd0;
        bus.funct7 = 7'b0000000; bus.rs2f = 5'd0; bus.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL fadd[%0d]: obs=%b expected=%b", i, obs, ev[i]);
            end
            if (i == 2) bus.req = 1'b0;
        end
    endtask

    task automatic test_fdiv();
        logic [12:0] ev [10];
        ev[0] = {5'b00100, 3'd2, 5'b10000};
        for (int i = 1; i < 8; i++) ev[i] = {5'b00000, 3'd2, 5'b10000};
        ev[8] = {5'b00000, 3'd2, 5'b11100};
        ev[9] = 13'd0;
        bus.funct7 = 7'b0001100; bus.rs2f = 5'd0; bus.req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL fdiv[%0d]: obs=%b expected=%b", i, obs, ev[i]);
            end
            if (i == 8) bus.req = 1'b0;
        end
    endtask

    task automatic test_feq();
        logic [12:0] ev [3];
        ev[0] = {5'b10000, 3'd4, 5'b10000};
        ev[1] = {5'b00000, 3'd4, 5'b11010};
        ev[2] = 13'd0;
        bus.funct7 = 7'b1010000; bus.rs2f = 5'd1; bus.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL feq[%0d]: obs=%b expected=%b", i, obs, ev[i]);
            end
            if (i == 1) bus.req = 1'b0;
        end
    endtask

    task automatic test_illegal();
        logic [12:0] ev [2];
        ev[0] = {5'b00000, 3'd0, 5'b11001};
        ev[1] = 13'd0;
        for (int k = 0; k < 2; k++) begin
            bus.funct7 = (k == 0) ? 7'b1111111 : 7'b0101100;
            bus.rs2f   = (k == 0) ? 5'd0 : 5'd3;
            bus.req    = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                n_checks++;
                if (obs !== ev[i]) begin
                    n_fail++;
                    $display("FAIL illegal%0d[%0d]: obs=%b expected=%b", k, i, obs, ev[i]);
                end
                if (i == 0) bus.req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [12:0] ev [16];
        ev[0] = {5'b01000, 3'd3, 5'b10000};
        for (int i = 1; i < 5; i++) ev[i] = {5'b00000, 3'd3, 5'b10000};
        ev[5] = 13'd0;
        ev[6] = {5'b01000, 3'd3, 5'b10000};
        for (int i = 7; i < 14; i++) ev[i] = {5'b00000, 3'd3, 5'b10000};
        ev[14] = {5'b00000, 3'd3, 5'b11100};
        ev[15] = 13'd0;
        bus.funct7 = 7'b0101100; bus.rs2f = 5'd0; bus.req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL sqrt_abort[%0d]: obs=%b expected=%b", i, obs, ev[i]);
            end
            if (i == 4)  rstn = 1'b0;
            if (i == 5)  rstn = 1'b1;
            if (i == 14) bus.req = 1'b0;
        end
    endtask

    task automatic test_mul_gap_add();
        logic [12:0] ev [10];
        ev[0] = {5'b00010, 3'd1, 5'b10000};
        ev[1] = {5'b00000, 3'd1, 5'b10000};
        ev[2] = {5'b00000, 3'd1, 5'b11100};
        ev[3] = 13'd0;
        ev[4] = 13'd0;
        ev[5] = 13'd0;
        ev[6] = {5'b00001, 3'd0, 5'b10000};
        ev[7] = {5'b00000, 3'd0, 5'b10000};
        ev[8] = {5'b00000, 3'd0, 5'b11100};
        ev[9] = 13'd0;
        bus.funct7 = 7'b0001000; bus.rs2f = 5'd0; bus.req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL mul_add[%0d]: obs=%b expected=%b", i, obs, ev[i]);
            end
            case (i)
                1: bus.funct7 = 7'b1010000;
                2: bus.req = 1'b0;
                5: begin bus.funct7 = 7'b0000000; bus.req = 1'b1; end
                7: bus.funct7 = 7'b1111111;
                8: bus.req = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] ev [6];
        ev[0] = {5'b10000, 3'd4, 5'b10000};
        ev[1] = {5'b00000, 3'd4, 5'b11100};
        ev[2] = 13'd0;
        ev[3] = {5'b10000, 3'd4, 5'b10000};
        ev[4] = {5'b00000, 3'd4, 5'b11010};
        ev[5] = 13'd0;
        bus.funct7 = 7'b1101000; bus.rs2f = 5'd0; bus.req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: obs=%b expected=%b", i, obs, ev[i]);
            end
            if (i == 1) bus.funct7 = 7'b1100000;
            if (i == 4) bus.req = 1'b0;
        end
    endtask

    task automatic test_decode();
        logic [6:0]  f7    [5];
        logic [4:0]  r2    [5];
        logic [12:0] first [5];
        logic [2:0]  wr    [5];
        logic [2:0]  flags;
        int          ndone;
        int          cyc;
        f7[0] = 7'b0000100; r2[0] = 5'd0; first[0] = {5'b00001, 3'd0, 5'b10000}; wr[0] = 3'b100;
        f7[1] = 7'b0010000; r2[1] = 5'd2; first[1] = {5'b10000, 3'd4, 5'b10000}; wr[1] = 3'b100;
        f7[2] = 7'b1110000; r2[2] = 5'd0; first[2] = {5'b10000, 3'd4, 5'b10000}; wr[2] = 3'b010;
        f7[3] = 7'b1111000; r2[3] = 5'd0; first[3] = {5'b10000, 3'd4, 5'b10000}; wr[3] = 3'b100;
        f7[4] = 7'b0101101; r2[4] = 5'd0; first[4] = {5'b00000, 3'd0, 5'b11001}; wr[4] = 3'b001;
        for (int k = 0; k < 5; k++) begin
            bus.funct7 = f7[k]; bus.rs2f = r2[k]; bus.req = 1'b1;
            ndone = 0; flags = 3'b000;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== first[k]) begin
                n_fail++;
                $display("FAIL decode%0d_first: obs=%b expected=%b", k, obs, first[k]);
            end
            if (bus.flpt_done) begin
                ndone++;
                flags = {bus.fregwrite, bus.iregwrite, bus.illegal};
            end
            // req drops mid-op; the op must still complete
            bus.req = 1'b0;
            cyc = 0;
            while (bus.busy && cyc < 12) begin
                @(posedge clk); #1;
                cyc++;
                if (bus.flpt_done) begin
                    ndone++;
                    flags = {bus.fregwrite, bus.iregwrite, bus.illegal};
                end
            end
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL decode%0d_timeout: busy=%b expected=0", k, bus.busy);
            end
            n_checks++;
            if (ndone != 1 || flags !== wr[k]) begin
                n_fail++;
                $display("FAIL decode%0d_done: pulses=%0d flags=%b expected pulses=1 flags=%b",
                         k, ndone, flags, wr[k]);
            end
        end
    endtask

    initial begin
        clk = 1'b0; rstn = 1'b0;
        bus.req = 1'b0; bus.funct7 = 7'd0; bus.rs2f = 5'd0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_fadd();
        test_fdiv();
        test_feq();
        test_illegal();
        test_reset_abort();
        test_mul_gap_add();
        test_back_to_back();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
